// File: rtl/mem_read_seq_if.sv
// Bundle of the read-sequencer signals: control inputs, the memory read port
// and the pair output towards the compute unit.
interface mem_read_seq_if;
    // burst control
    logic         start;
    logic         abort;
    logic [4:0]   base_addr;
    logic [4:0]   len;
    logic         busy;
    logic         done;
    // main-memory read port
    logic [1:0]   R_am;
    logic [4:0]   R_addr;
    logic [63:0]  mem_d1;
    logic [63:0]  mem_d2;
    // pair output to the compute unit
    logic [127:0] pair_data;
    logic         pair_valid;
    logic         pair_ready;

    // sequencer side
    modport slave (
        input  start, abort, base_addr, len, mem_d1, mem_d2, pair_ready,
        output busy, done, R_am, R_addr, pair_data, pair_valid
    );

    // controller / memory / compute-unit side
    modport master (
        output start, abort, base_addr, len, mem_d1, mem_d2, pair_ready,
        input  busy, done, R_am, R_addr, pair_data, pair_valid
    );
endinterface

// File: rtl/mem_read_seq.sv
// Burst read sequencer: reads len word pairs starting at base_addr (step 2,
// 5-bit wrap) and hands each {mem[a+1], mem[a]} to the compute unit over a
// valid/ready handshake. One pair in flight at a time: ISSUE -> LOAD -> OUT.
module mem_read_seq (
    input  logic          clk,
    input  logic          rst,
    mem_read_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LOAD  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     cur_addr_q, cur_addr_d;
    logic [4:0]     remaining_q, remaining_d;
    logic [4:0]     r_addr_q, r_addr_d;
    logic [127:0]   pair_data_q, pair_data_d;
    logic           pair_valid_q, pair_valid_d;

    logic [1:0]     r_am;
    logic           busy_o;
    logic           done_o;

    logic           handshake;
    logic           last_pair;
    logic [4:0]     next_addr;

    // pair accepted by the compute unit on this edge
    assign handshake = (state_q == S_OUT) && pair_valid_q && bus.pair_ready;
    assign last_pair = (remaining_q == 5'd1);
    // 5-bit arithmetic gives the address wrap for free (31 -> 1)
    assign next_addr = cur_addr_q + 5'd2;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // next-state logic; abort overrides everything else
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start) state_d = (bus.len == 5'd0) ? S_DONE : S_ISSUE;
                S_ISSUE: state_d = S_LOAD;
                S_LOAD:  state_d = S_OUT;
                S_OUT:   if (handshake) state_d = last_pair ? S_DONE : S_ISSUE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // datapath next values: burst counters, read address, pair capture
    always_comb begin
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        r_addr_d     = r_addr_q;
        pair_data_d  = pair_data_q;
        pair_valid_d = pair_valid_q;
        if (bus.abort) begin
            pair_valid_d = 1'b0;
            remaining_d  = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cur_addr_d  = bus.base_addr;
                        remaining_d = bus.len;
                        // R_addr only moves when a read is about to be issued
                        if (bus.len != 5'd0) r_addr_d = bus.base_addr;
                    end
                end
                S_LOAD: begin
                    // memory data is valid in the cycle after the read edge
                    pair_data_d  = {bus.mem_d2, bus.mem_d1};
                    pair_valid_d = 1'b1;
                end
                S_OUT: begin
                    if (handshake) begin
                        pair_valid_d = 1'b0;
                        remaining_d  = remaining_q - 5'd1;
                        cur_addr_d   = next_addr;
                        if (!last_pair) r_addr_d = next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr_q   <= 5'd0;
            remaining_q  <= 5'd0;
            r_addr_q     <= 5'd0;
            pair_data_q  <= 128'd0;
            pair_valid_q <= 1'b0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            r_addr_q     <= r_addr_d;
            pair_data_q  <= pair_data_d;
            pair_valid_q <= pair_valid_d;
        end
    end

    // state-decoded outputs: read strobe, busy, done pulse
    always_comb begin
        r_am   = 2'b11;
        busy_o = 1'b1;
        done_o = 1'b0;
        case (state_q)
            S_IDLE:  busy_o = 1'b0;
            S_ISSUE: r_am   = 2'b00;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.R_am       = r_am;
    assign bus.R_addr     = r_addr_q;
    assign bus.pair_data  = pair_data_q;
    assign bus.pair_valid = pair_valid_q;
    assign bus.busy       = busy_o;
    assign bus.done       = done_o;

endmodule

// File: tb/tb_mem_read_seq.sv
// Bench for mem_read_seq: directed corner bursts plus a randomized phase,
// all checked every cycle against a transaction-level model of the sequencer.
module tb_mem_read_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_read_seq_if bus();
    mem_read_seq dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] mem [32];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // memory: synchronous read, data appears the cycle after an R_am=00 edge
    logic [4:0] rd_a1;
    always @(posedge clk) begin
        rd_a1 = bus.R_addr + 5'd1;
        if (bus.R_am == 2'b00) begin
            bus.mem_d1 <= mem[bus.R_addr];
            bus.mem_d2 <= mem[rd_a1];
        end
    end

    // reference: a burst is a list of pairs; each pair is requested, shown
    // two edges later, held until accepted; done follows the final accept.
    bit           m_busy  = 0;
    bit           m_done  = 0;
    bit           m_valid = 0;
    int           m_left  = 0;
    int           m_age   = 0;
    logic [4:0]   m_addr  = 0;
    logic [4:0]   m_raddr = 0;
    logic [4:0]   m_a1;
    logic [127:0] m_data  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_left = 0; m_age = 0;
            m_addr = 0; m_raddr = 0; m_data = 0;
        end else if (bus.abort) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1;
                m_addr = bus.base_addr;
                m_left = int'(bus.len);
                if (bus.len == 5'd0) m_done = 1;
                else begin m_age = 0; m_raddr = bus.base_addr; end
            end
        end else if (m_valid) begin
            if (bus.pair_ready) begin
                m_valid = 0;
                m_left--;
                m_addr = m_addr + 5'd2;
                if (m_left == 0) m_done = 1;
                else begin m_age = 0; m_raddr = m_addr; end
            end
        end else begin
            m_age++;
            if (m_age == 2) begin
                m_a1 = m_addr + 5'd1;
                m_valid = 1;
                m_data = {mem[m_a1], mem[m_addr]};
            end
        end
    end

    // compare DUT to model mid-cycle, and log handshakes/reads for directed checks
    logic [127:0] obs[$];
    logic [4:0]   raddr_q[$];
    int           n_issue = 0;
    int           n_done  = 0;
    logic [1:0]   exp_am;

    always @(negedge clk) begin
        exp_am = (m_busy && !m_done && !m_valid && m_age == 0) ? 2'b00 : 2'b11;
        chk("R_am",       128'(bus.R_am),       128'(exp_am));
        chk("R_addr",     128'(bus.R_addr),     128'(m_raddr));
        chk("pair_valid", 128'(bus.pair_valid), 128'(m_valid));
        chk("pair_data",  bus.pair_data,        m_data);
        chk("busy",       128'(bus.busy),       128'(m_busy));
        chk("done",       128'(bus.done),       128'(m_done));
        if (rst && !bus.abort && bus.pair_valid && bus.pair_ready) obs.push_back(bus.pair_data);
        if (bus.R_am == 2'b00) begin
            n_issue++;
            raddr_q.push_back(bus.R_addr);
        end
        if (bus.done) n_done++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [4:0] b, input logic [4:0] l);
        bus.start = 1'b1; bus.base_addr = b; bus.len = l;
        cyc();
        bus.start = 1'b0;
        bus.base_addr = 5'($urandom); bus.len = 5'($urandom);
    endtask

    task automatic wait_valid(input string nm, input int max);
        int n = 0;
        while (!bus.pair_valid && n < max) begin cyc(); n++; end
        if (!bus.pair_valid) begin errors++; $display("FAIL %s: pair_valid timeout got 0 expected 1", nm); end
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n = 0;
        while (bus.busy && n < max) begin cyc(); n++; end
        if (bus.busy) begin errors++; $display("FAIL %s: busy timeout got 1 expected 0", nm); end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_R_am"},  128'(bus.R_am),       128'(2'b11));
        chk({nm, "_R_addr"},128'(bus.R_addr),     128'd0);
        chk({nm, "_data"},  bus.pair_data,        128'd0);
        chk({nm, "_valid"}, 128'(bus.pair_valid), 128'd0);
        chk({nm, "_busy"},  128'(bus.busy),       128'd0);
        chk({nm, "_done"},  128'(bus.done),       128'd0);
    endtask

    // assert reset mid-cycle (called at posedge+1), check, release mid-cycle
    task automatic reset_pulse(input string nm);
        #2 rst = 1'b0;
        #1 chk_reset_vals(nm);
        @(posedge clk);
        #3 rst = 1'b1;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, r0, ni, nd;
        logic [127:0] d0;

        bus.start = 0; bus.abort = 0; bus.base_addr = 0; bus.len = 0; bus.pair_ready = 1;
        for (int i = 0; i < 32; i++) mem[i] = 64'(i);

        // power-up reset
        #2 rst = 1'b0;
        #1 chk_reset_vals("por");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        cyc();

        // basic burst with latency check
        i0 = obs.size(); ni = n_issue; nd = n_done;
        go(5'd4, 5'd2);
        chk("lat_t1", 128'(bus.pair_valid), 128'd0);
        cyc();
        chk("lat_t2", 128'(bus.pair_valid), 128'd0);
        cyc();
        chk("lat_t3", 128'(bus.pair_valid), 128'd1);
        wait_idle("basic", 40);
        cyc();
        chk("basic_npairs", 128'(obs.size() - i0), 128'd2);
        chk("basic_p0", obs[i0],   {64'd5, 64'd4});
        chk("basic_p1", obs[i0+1], {64'd7, 64'd6});
        chk("basic_issues", 128'(n_issue - ni), 128'd2);
        chk("basic_dones",  128'(n_done - nd),  128'd1);

        // address wrap
        i0 = obs.size(); r0 = raddr_q.size();
        go(5'd31, 5'd2);
        wait_idle("wrap", 40);
        cyc();
        chk("wrap_p0", obs[i0],   {64'd0, 64'd31});
        chk("wrap_p1", obs[i0+1], {64'd2, 64'd1});
        chk("wrap_ra0", 128'(raddr_q[r0]),   128'd31);
        chk("wrap_ra1", 128'(raddr_q[r0+1]), 128'd1);

        // backpressure
        bus.pair_ready = 0; ni = n_issue;
        go(5'd10, 5'd1);
        wait_valid("bp", 10);
        d0 = bus.pair_data;
        chk("bp_data", d0, {64'd11, 64'd10});
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_hold", bus.pair_data, d0);
            chk("bp_am", 128'(bus.R_am), 128'(2'b11));
        end
        bus.pair_ready = 1;
        cyc();
        chk("bp_done", 128'(bus.done), 128'd1);
        cyc();
        chk("bp_done_end", 128'(bus.done), 128'd0);
        chk("bp_issues", 128'(n_issue - ni), 128'd1);

        // len = 0
        ni = n_issue; nd = n_done;
        go(5'd7, 5'd0);
        chk("len0_done", 128'(bus.done), 128'd1);
        cyc();
        chk("len0_done_end", 128'(bus.done), 128'd0);
        chk("len0_busy", 128'(bus.busy), 128'd0);
        chk("len0_issues", 128'(n_issue - ni), 128'd0);
        chk("len0_dones",  128'(n_done - nd),  128'd1);

        // start during a burst is ignored
        i0 = obs.size(); nd = n_done;
        go(5'd8, 5'd2);
        cyc();
        bus.start = 1; bus.base_addr = 5'd20; bus.len = 5'd5;
        cyc();
        bus.start = 0;
        wait_idle("restart", 60);
        cyc();
        chk("restart_npairs", 128'(obs.size() - i0), 128'd2);
        chk("restart_p0", obs[i0],   {64'd9, 64'd8});
        chk("restart_p1", obs[i0+1], {64'd11, 64'd10});
        chk("restart_dones", 128'(n_done - nd), 128'd1);

        // abort while holding a pair
        bus.pair_ready = 0; nd = n_done;
        go(5'd0, 5'd3);
        wait_valid("abort", 10);
        bus.abort = 1;
        cyc();
        bus.abort = 0;
        chk("abort_valid", 128'(bus.pair_valid), 128'd0);
        chk("abort_busy",  128'(bus.busy),       128'd0);
        repeat (4) cyc();
        chk("abort_dones", 128'(n_done - nd), 128'd0);
        bus.pair_ready = 1;

        // reset during LOAD, then a fresh burst
        nd = n_done;
        go(5'd2, 5'd2);
        cyc();
        reset_pulse("rst_load");
        chk("rst_load_dones", 128'(n_done - nd), 128'd0);
        i0 = obs.size();
        go(5'd0, 5'd1);
        wait_idle("fresh", 40);
        cyc();
        chk("fresh_p0", obs[i0], {64'd1, 64'd0});

        // randomized traffic over random memory contents
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        for (int c = 0; c < 1500; c++) begin
            bus.start      = ($urandom % 4) == 0;
            bus.base_addr  = 5'($urandom);
            bus.len        = (($urandom % 8) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            bus.abort      = ($urandom % 50) == 0;
            bus.pair_ready = ($urandom % 3) != 0;
            if (($urandom % 200) == 0) reset_pulse("rnd_rst");
            else cyc();
        end
        bus.start = 0; bus.abort = 0; bus.pair_ready = 1;
        wait_idle("final", 200);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
